mig_read_req_generator: RTL and testbench

- Scanout-side counterpart of the framebuffer write path.
- On a frame start pulse, issues one 128-bit MIG read request per 8-pixel word of the selected framebuffer, in raster order.
- Unpacks each returned word into eight 16-bit pixels, tagged with hcount/vcount, and streams them to the display pipeline over a valid/ready handshake.
- Caps in-flight reads so the MIG read-return FIFO never overflows.

---
 rtl/fb_pkg.sv | 24 ++
 rtl/mig_word_unpacker.sv | 82 ++++++++
 rtl/mig_read_req_generator.sv | 128 ++++++++++++
 tb/tb_mig_read_req_generator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions for the MIG read and write generators.
// Word geometry, address layout and the read-side FSM state type.
package fb_pkg;

  localparam int FB_ADDR_W    = 27;
  localparam int FB_DATA_W    = 128;
  localparam int PIX_W        = 16;
  localparam int PIX_PER_WORD = 8;
  localparam int FRAME_BIT    = 26;
  localparam int PIX_IDX_W    = $clog2(PIX_PER_WORD);

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

  // Byte address of a 16-byte word: frame select on the top bit, word offset below.
  function automatic logic [FB_ADDR_W-1:0] fb_word_addr(input logic frame,
                                                        input logic [FRAME_BIT-1:0] word_idx);
    return {frame, FRAME_BIT'(word_idx << 4)};
  endfunction

endpackage

// File: rtl/mig_word_unpacker.sv
// Serializes 128-bit read-return words into eight 16-bit pixels, pixel 0 first,
// and tracks the raster position of the pixel being presented.
module mig_word_unpacker
  import fb_pkg::*;
#(
  parameter int  HRES   = 64,
  parameter int  VRES   = 36,
  localparam int HCNT_W = $clog2(HRES),
  localparam int VCNT_W = $clog2(VRES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_clear,
  input  logic [FB_DATA_W-1:0] i_data,
  input  logic                 i_data_valid,
  output logic                 o_data_rdy,
  output logic [PIX_W-1:0]     o_pixel,
  output logic [HCNT_W-1:0]    o_hcount,
  output logic [VCNT_W-1:0]    o_vcount,
  output logic                 o_pixel_valid,
  input  logic                 i_pixel_rdy,
  output logic                 o_last_pix
);

  logic [FB_DATA_W-1:0] r_word;
  logic [PIX_IDX_W-1:0] r_pix_idx;
  logic                 r_full;
  logic [HCNT_W-1:0]    r_hcount;
  logic [VCNT_W-1:0]    r_vcount;

  logic w_consume;
  logic w_load;
  logic w_idx_last;
  logic w_line_end;
  logic w_frame_end;

  assign w_consume   = r_full && i_pixel_rdy;
  assign w_idx_last  = (r_pix_idx == PIX_IDX_W'(PIX_PER_WORD - 1));
  // Accepting a new word while the final pixel drains keeps the stream bubble-free.
  assign o_data_rdy  = i_en && (!r_full || (w_idx_last && w_consume));
  assign w_load      = i_data_valid && o_data_rdy;
  assign w_line_end  = (r_hcount == HCNT_W'(HRES - 1));
  assign w_frame_end = w_line_end && (r_vcount == VCNT_W'(VRES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_word    <= '0;
      r_pix_idx <= '0;
      r_full    <= 1'b0;
      r_hcount  <= '0;
      r_vcount  <= '0;
    end else begin
      if (w_load) begin
        r_word    <= i_data;
        r_pix_idx <= '0;
        r_full    <= 1'b1;
      end else if (w_consume) begin
        r_pix_idx <= r_pix_idx + 1'b1;
        if (w_idx_last) begin
          r_full <= 1'b0;
        end
      end

      if (w_consume) begin
        if (w_line_end) begin
          r_hcount <= '0;
          r_vcount <= w_frame_end ? '0 : r_vcount + 1'b1;
        end else begin
          r_hcount <= r_hcount + 1'b1;
        end
      end
    end
  end

  assign o_pixel       = r_full ? r_word[PIX_W*r_pix_idx +: PIX_W] : '0;
  assign o_pixel_valid = r_full;
  assign o_hcount      = r_hcount;
  assign o_vcount      = r_vcount;
  assign o_last_pix    = w_consume && w_frame_end;

endmodule

// File: rtl/mig_read_req_generator.sv
// Scanout read path: streams one framebuffer out of MIG as raster-ordered pixels,
// limiting in-flight reads so the MIG read-return FIFO cannot overflow.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RD_IDLE  | waiting for start_in; no requests, returns not accepted
// RD_RUN   | issuing word reads while under the outstanding cap
// RD_DRAIN | all reads issued; streaming remaining pixels to the display
module mig_read_req_generator
  import fb_pkg::*;
#(
  parameter int  HRES            = 64,
  parameter int  VRES            = 36,
  parameter int  MAX_OUTSTANDING = 8,
  localparam int HCNT_W          = $clog2(HRES),
  localparam int VCNT_W          = $clog2(VRES)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 frame_in,
  output logic [FB_ADDR_W-1:0] addr_out,
  output logic                 addr_valid_out,
  input  logic                 addr_rdy_in,
  input  logic [FB_DATA_W-1:0] data_in,
  input  logic                 data_valid_in,
  output logic                 data_rdy_out,
  output logic [PIX_W-1:0]     pixel_out,
  output logic [HCNT_W-1:0]    hcount_out,
  output logic [VCNT_W-1:0]    vcount_out,
  output logic                 pixel_valid_out,
  input  logic                 pixel_rdy_in,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int WORDS = HRES * VRES / PIX_PER_WORD;
  localparam int REQ_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  rd_state_t r_state;
  rd_state_t w_state_nxt;

  logic             r_frame;
  logic [REQ_W-1:0] r_req_idx;
  logic [OUT_W-1:0] r_outstanding;
  logic             r_done;

  logic w_busy;
  logic w_start;
  logic w_req_fire;
  logic w_ret_fire;
  logic w_last_req;
  logic w_last_pix;

  assign w_busy         = (r_state != RD_IDLE);
  assign w_start        = (r_state == RD_IDLE) && start_in;
  assign addr_valid_out = (r_state == RD_RUN) && (r_outstanding < OUT_W'(MAX_OUTSTANDING));
  assign addr_out       = fb_word_addr(r_frame, FRAME_BIT'(r_req_idx));
  assign w_req_fire     = addr_valid_out && addr_rdy_in;
  assign w_ret_fire     = data_valid_in && data_rdy_out;
  assign w_last_req     = (r_req_idx == REQ_W'(WORDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_IDLE:  if (start_in) w_state_nxt = RD_RUN;
      RD_RUN:   if (w_req_fire && w_last_req) w_state_nxt = RD_DRAIN;
      RD_DRAIN: if (w_last_pix) w_state_nxt = RD_IDLE;
      default:  w_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= RD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_frame       <= 1'b0;
      r_req_idx     <= '0;
      r_outstanding <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done <= (r_state == RD_DRAIN) && w_last_pix;

      if (w_start) begin
        r_frame   <= frame_in;
        r_req_idx <= '0;
      end else if (w_req_fire) begin
        r_req_idx <= w_last_req ? '0 : r_req_idx + 1'b1;
      end

      case ({w_req_fire, w_ret_fire})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  mig_word_unpacker #(
    .HRES (HRES),
    .VRES (VRES)
  ) u_unpacker (
    .i_clk         (clk_in),
    .i_rst         (rst_in),
    .i_en          (w_busy),
    .i_clear       (w_start),
    .i_data        (data_in),
    .i_data_valid  (data_valid_in),
    .o_data_rdy    (data_rdy_out),
    .o_pixel       (pixel_out),
    .o_hcount      (hcount_out),
    .o_vcount      (vcount_out),
    .o_pixel_valid (pixel_valid_out),
    .i_pixel_rdy   (pixel_rdy_in),
    .o_last_pix    (w_last_pix)
  );

  assign busy_out = w_busy;
  assign done_out = r_done;

endmodule

// File: tb/tb_mig_read_req_generator.sv
// Bench for mig_read_req_generator: a MIG-like memory model answers reads in order,
// and a frame-level model predicts addresses, handshakes and the pixel stream.
module tb_mig_read_req_generator;

  localparam int HRES  = 16;
  localparam int VRES  = 4;
  localparam int MAXO  = 2;
  localparam int WORDS = HRES * VRES / 8;
  localparam int NPIX  = WORDS * 8;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         start_in;
  logic         frame_in;
  logic [26:0]  addr_out;
  logic         addr_valid_out;
  logic         addr_rdy_in;
  logic [127:0] data_in;
  logic         data_valid_in;
  logic         data_rdy_out;
  logic [15:0]  pixel_out;
  logic [3:0]   hcount_out;
  logic [1:0]   vcount_out;
  logic         pixel_valid_out;
  logic         pixel_rdy_in;
  logic         busy_out;
  logic         done_out;

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] pend[$];
  logic [127:0] rw[$];

  always #5 clk_in = ~clk_in;

  mig_read_req_generator #(
    .HRES            (HRES),
    .VRES            (VRES),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .frame_in        (frame_in),
    .addr_out        (addr_out),
    .addr_valid_out  (addr_valid_out),
    .addr_rdy_in     (addr_rdy_in),
    .data_in         (data_in),
    .data_valid_in   (data_valid_in),
    .data_rdy_out    (data_rdy_out),
    .pixel_out       (pixel_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .pixel_valid_out (pixel_valid_out),
    .pixel_rdy_in    (pixel_rdy_in),
    .busy_out        (busy_out),
    .done_out        (done_out)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"},        addr_out, 0);
    chk({tag, "_addr_valid"},  addr_valid_out, 0);
    chk({tag, "_data_rdy"},    data_rdy_out, 0);
    chk({tag, "_pixel"},       pixel_out, 0);
    chk({tag, "_hcount"},      hcount_out, 0);
    chk({tag, "_vcount"},      vcount_out, 0);
    chk({tag, "_pixel_valid"}, pixel_valid_out, 0);
    chk({tag, "_busy"},        busy_out, 0);
    chk({tag, "_done"},        done_out, 0);
  endtask

  // Deterministic words carry their own linear pixel number in every lane.
  function automatic logic [127:0] gen_word(input bit det, input int k);
    logic [127:0] w;
    if (det) begin
      for (int j = 0; j < 8; j++) w[16*j +: 16] = 16'(8*k + j);
    end else begin
      w = {$urandom, $urandom, $urandom, $urandom};
    end
    return w;
  endfunction

  task automatic drive(input int cyc, input int ardy_mode, input int prdy_mode);
    start_in = 1'b0;
    case (ardy_mode)
      0: addr_rdy_in = 1'b1;
      1: begin
        addr_rdy_in = 1'($urandom_range(0, 1));
        start_in    = ($urandom_range(0, 7) == 0);
        frame_in    = 1'($urandom_range(0, 1));
      end
      default: addr_rdy_in = !(cyc >= 3 && cyc < 8);
    endcase
    case (prdy_mode)
      0:       pixel_rdy_in = 1'b1;
      1:       pixel_rdy_in = (cyc % 2 == 0);
      default: pixel_rdy_in = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_frame(input logic fr, input int ardy_mode, input int prdy_mode,
                           input int ret_mode, input bit det, input int abort_at);
    int cyc, exp_req, m_out, pix_n, buffered;
    bit last_fire, hold_prev, req_f, ret_f, pix_f, present;
    logic [26:0]  prev_addr, ea;
    logic [127:0] w;
    pend.delete();
    rw.delete();
    cyc = 0; exp_req = 0; m_out = 0; pix_n = 0;
    last_fire = 0; hold_prev = 0; prev_addr = '0;
    frame_in = fr;
    start_in = 1'b1;
    @(posedge clk_in);
    #1;
    drive(0, ardy_mode, prdy_mode);
    start_in = 1'b0;
    frame_in = ~fr;
    forever begin
      @(negedge clk_in);
      buffered = rw.size() * 8 - pix_n;
      if (last_fire) begin
        chk("done_pulse", done_out, 1);
        chk("busy_end", busy_out, 0);
        chk("addr_valid_end", addr_valid_out, 0);
        chk("pixel_valid_end", pixel_valid_out, 0);
        @(negedge clk_in);
        chk("done_once", done_out, 0);
        return;
      end
      if (cyc >= 3000) begin
        chk("timeout_pixels", pix_n, NPIX);
        return;
      end
      chk("busy", busy_out, 1);
      chk("done_early", done_out, 0);
      chk("addr_valid", addr_valid_out, (exp_req < WORDS) && (m_out < MAXO));
      chk("pixel_valid", pixel_valid_out, buffered > 0);
      chk("data_rdy", data_rdy_out, (buffered == 0) || (buffered == 1 && pixel_rdy_in));
      if (hold_prev) chk("addr_hold", addr_out, prev_addr);
      req_f = addr_valid_out && addr_rdy_in;
      ret_f = data_valid_in && data_rdy_out;
      pix_f = pixel_valid_out && pixel_rdy_in;
      if (req_f) begin
        ea = (fr ? 27'h4000000 : 27'h0) + 27'(exp_req * 16);
        chk("addr", addr_out, ea);
      end
      if (pix_f) begin
        w = (pix_n / 8 < rw.size()) ? rw[pix_n / 8] : '0;
        chk("pixel", pixel_out, w[16*(pix_n % 8) +: 16]);
        chk("hcount", hcount_out, pix_n % HRES);
        chk("vcount", vcount_out, pix_n / HRES);
      end
      hold_prev = addr_valid_out && !addr_rdy_in;
      prev_addr = addr_out;

      @(posedge clk_in);
      if (req_f) begin
        pend.push_back(gen_word(det, exp_req));
        exp_req++;
        m_out++;
      end
      if (ret_f && pend.size() > 0) begin
        rw.push_back(pend.pop_front());
        m_out--;
      end
      if (pix_f) begin
        pix_n++;
        if (pix_n == NPIX) last_fire = 1;
      end
      cyc++;
      #1;

      if (abort_at >= 0 && pix_n == abort_at) begin
        rst_in        = 1'b1;
        start_in      = 1'b0;
        data_valid_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk_zero("abort");
        @(negedge clk_in);
        chk("abort_no_done", done_out, 0);
        return;
      end

      if (ret_f) data_valid_in = 1'b0;
      if (last_fire) begin
        start_in      = 1'b0;
        data_valid_in = 1'b0;
      end else begin
        drive(cyc, ardy_mode, prdy_mode);
        present = (ret_mode == 0) ||
                  (ret_mode == 1 && $urandom_range(0, 1) == 1) ||
                  (ret_mode == 2 && cyc >= 8);
        if (!data_valid_in && pend.size() > 0 && present) begin
          data_valid_in = 1'b1;
          data_in       = pend[0];
        end else if (!data_valid_in) begin
          data_in = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  endtask

  initial begin
    rst_in        = 1'b1;
    start_in      = 1'b0;
    frame_in      = 1'b0;
    addr_rdy_in   = 1'b0;
    data_in       = '0;
    data_valid_in = 1'b0;
    pixel_rdy_in  = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk_zero("reset");
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    chk_zero("idle");

    run_frame(1'b1, 0, 0, 0, 1'b1, -1);   // frame 1, free-flowing, known pixel values
    run_frame(1'b0, 0, 0, 2, 1'b0, -1);   // returns withheld: outstanding cap
    run_frame(1'b1, 0, 1, 0, 1'b1, -1);   // pixel_rdy toggling
    run_frame(1'b0, 2, 0, 0, 1'b1, -1);   // addr_rdy low for 5 cycles
    run_frame(1'b1, 1, 2, 1, 1'b0, 10);   // reset after 10 pixels
    run_frame(1'b0, 0, 0, 0, 1'b1, -1);   // restart on frame 0
    for (int i = 0; i < 6; i++) begin
      run_frame(1'($urandom_range(0, 1)), 1, 2, 1, 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
